// File: rtl/reservation_station.sv
// reservation_station: single-ALU out-of-order reservation station with CDB wakeup and one-cycle result broadcast
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int ROB_BITS = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                rob_clear,
  output logic                rs_full,
  input  logic                is_ins,
  input  logic [3:0]          ins_op,
  input  logic                ins_is_br,
  input  logic [ROB_BITS-1:0] ins_rob_id,
  input  logic                ins_rj_ready,
  input  logic [31:0]         ins_vj,
  input  logic [ROB_BITS-1:0] ins_qj,
  input  logic                ins_rk_ready,
  input  logic [31:0]         ins_vk,
  input  logic [ROB_BITS-1:0] ins_qk,
  input  logic                lsb_has_output,
  input  logic [ROB_BITS-1:0] lsb_rob_id,
  input  logic [31:0]         lsb_output,
  output logic                rs_has_output,
  output logic [ROB_BITS-1:0] rs_rob_id,
  output logic [31:0]         rs_output
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy, rj, rk, br;
  logic [3:0] op [RS_SIZE];
  logic [ROB_BITS-1:0] rob [RS_SIZE];
  logic [ROB_BITS-1:0] qj [RS_SIZE];
  logic [ROB_BITS-1:0] qk [RS_SIZE];
  logic [31:0] vj [RS_SIZE];
  logic [31:0] vk [RS_SIZE];
  logic [IW-1:0] sel, slot;
  logic sel_ok;
  logic [IW:0] n_busy;
  function automatic logic [32:0] wake(input logic r, input logic [31:0] v, input logic [ROB_BITS-1:0] q);
    return r ? {1'b1, v} :
           rs_has_output && q == rs_rob_id ? {1'b1, rs_output} :
           lsb_has_output && q == lsb_rob_id ? {1'b1, lsb_output} : {1'b0, v};
  endfunction
  function automatic logic [31:0] alu(input logic [3:0] o, input logic b, input logic [31:0] x, input logic [31:0] y);
    logic lt, ltu;
    lt = $signed(x) < $signed(y);
    ltu = x < y;
    if (b) return {31'b0, (o[2] ? (o[1] ? ltu : lt) : x == y) ^ o[0]};
    case (o)
      4'b0000: return x + y;
      4'b1000: return x - y;
      4'b0001: return x << y[4:0];
      4'b0010: return {31'b0, lt};
      4'b0011: return {31'b0, ltu};
      4'b0100: return x ^ y;
      4'b0101: return x >> y[4:0];
      4'b1101: return $signed(x) >>> y[4:0];
      4'b0110: return x | y;
      4'b0111: return x & y;
      default: return '0;
    endcase
  endfunction
  always_comb begin
    sel = '0;
    sel_ok = 1'b0;
    slot = '0;
    n_busy = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy[i] && rj[i] && rk[i]) begin
        sel = IW'(i);
        sel_ok = 1'b1;
      end
      if (!busy[i]) slot = IW'(i);
      n_busy = n_busy + (IW+1)'(busy[i]);
    end
  end
  assign rs_full = n_busy > (IW+1)'(RS_SIZE - 2);
  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && rob_clear)) begin
      busy <= '0;
      rs_has_output <= 1'b0;
      rs_rob_id <= '0;
      rs_output <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        {rj[i], vj[i]} <= wake(rj[i], vj[i], qj[i]);
        {rk[i], vk[i]} <= wake(rk[i], vk[i], qk[i]);
      end
      if (sel_ok) busy[sel] <= 1'b0;
      if (is_ins && !rs_full) begin
        busy[slot] <= 1'b1;
        op[slot] <= ins_op;
        br[slot] <= ins_is_br;
        rob[slot] <= ins_rob_id;
        qj[slot] <= ins_qj;
        qk[slot] <= ins_qk;
        {rj[slot], vj[slot]} <= wake(ins_rj_ready, ins_vj, ins_qj);
        {rk[slot], vk[slot]} <= wake(ins_rk_ready, ins_vk, ins_qk);
      end
      rs_has_output <= sel_ok;
      rs_rob_id <= rob[sel];
      rs_output <= alu(op[sel], br[sel], vj[sel], vk[sel]);
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: randomized scoreboard bench for reservation_station
module tb_reservation_station;
  localparam int RS = 8;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, rob_clear, rs_full, is_ins, ins_is_br, ins_rj_ready, ins_rk_ready;
  logic lsb_has_output, rs_has_output;
  logic [3:0] ins_op;
  logic [2:0] ins_rob_id, ins_qj, ins_qk, lsb_rob_id, rs_rob_id;
  logic [31:0] ins_vj, ins_vk, lsb_output, rs_output;
  always #5 clk_in = ~clk_in;
  reservation_station #(.RS_SIZE(RS), .ROB_BITS(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear), .rs_full(rs_full),
    .is_ins(is_ins), .ins_op(ins_op), .ins_is_br(ins_is_br), .ins_rob_id(ins_rob_id),
    .ins_rj_ready(ins_rj_ready), .ins_vj(ins_vj), .ins_qj(ins_qj),
    .ins_rk_ready(ins_rk_ready), .ins_vk(ins_vk), .ins_qk(ins_qk),
    .lsb_has_output(lsb_has_output), .lsb_rob_id(lsb_rob_id), .lsb_output(lsb_output),
    .rs_has_output(rs_has_output), .rs_rob_id(rs_rob_id), .rs_output(rs_output)
  );
  typedef struct {
    logic [3:0] op;
    logic br;
    logic [2:0] rob;
    logic rj, rk;
    logic [31:0] vj, vk;
    logic [2:0] qj, qk;
  } ent_t;
  ent_t pend[$];
  logic [31:0] exp_val [int];
  int seen[$];
  int n_chk = 0;
  int n_fail = 0;
  logic last_rdy = 1'b0;
  logic [3:0] alu_ops [10] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hd, 4'h6, 4'h7};
  logic [2:0] br_ops [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic br, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic t;
    sa = int'(a);
    sb = int'(b);
    t = 1'b0;
    if (br) begin
      case (op[2:0])
        3'd0: t = a == b;
        3'd1: t = a != b;
        3'd4: t = sa < sb;
        3'd5: t = sa >= sb;
        3'd6: t = a < b;
        3'd7: t = a >= b;
        default: t = 1'b0;
      endcase
      return {31'd0, t};
    end
    case (op)
      4'h0: return a + b;
      4'h8: return a + ~b + 32'd1;
      4'h1: return a << b[4:0];
      4'h2: return {31'd0, sa < sb};
      4'h3: return {31'd0, a < b};
      4'h4: return a ^ b;
      4'h5: return a >> b[4:0];
      4'hd: return 32'(sa >>> b[4:0]);
      4'h6: return a | b;
      4'h7: return a & b;
      default: return 32'd0;
    endcase
  endfunction
  function automatic ent_t wake(input ent_t e);
    if (lsb_has_output && !e.rj && e.qj == lsb_rob_id) begin
      e.rj = 1'b1;
      e.vj = lsb_output;
    end
    if (lsb_has_output && !e.rk && e.qk == lsb_rob_id) begin
      e.rk = 1'b1;
      e.vk = lsb_output;
    end
    return e;
  endfunction
  function automatic int outstanding();
    return pend.size() + exp_val.num();
  endfunction
  function automatic bit used(input int r);
    foreach (pend[i]) if (int'(pend[i].rob) == r) return 1'b1;
    return exp_val.exists(r);
  endfunction
  task automatic model_edge();
    ent_t e;
    last_rdy = rdy_in;
    if (rst_in || (rdy_in && rob_clear)) begin
      pend.delete();
      exp_val.delete();
      return;
    end
    if (!rdy_in) return;
    foreach (pend[i]) pend[i] = wake(pend[i]);
    if (is_ins && pend.size() < RS - 1) begin
      e = '{ins_op, ins_is_br, ins_rob_id, ins_rj_ready, ins_rk_ready, ins_vj, ins_vk, ins_qj, ins_qk};
      pend.push_back(wake(e));
    end
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].rj && pend[i].rk) begin
        exp_val[int'(pend[i].rob)] = ref_alu(pend[i].op, pend[i].br, pend[i].vj, pend[i].vk);
        pend.delete(i);
      end
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    is_ins = 1'b0;
    lsb_has_output = 1'b0;
    rob_clear = 1'b0;
  endtask
  task automatic issue(input logic [3:0] op, input logic br, input logic [2:0] rob,
                       input logic rj, input logic [31:0] vj, input logic [2:0] qj,
                       input logic rk, input logic [31:0] vk, input logic [2:0] qk);
    is_ins = 1'b1;
    ins_op = op;
    ins_is_br = br;
    ins_rob_id = rob;
    ins_rj_ready = rj;
    ins_vj = vj;
    ins_qj = qj;
    ins_rk_ready = rk;
    ins_vk = vk;
    ins_qk = qk;
  endtask
  task automatic lsb(input logic [2:0] t, input logic [31:0] v);
    lsb_has_output = 1'b1;
    lsb_rob_id = t;
    lsb_output = v;
  endtask
  task automatic drain(input int budget);
    int c;
    c = 0;
    while (outstanding() != 0 && c < budget) begin
      lsb(3'($urandom_range(7, 6)), $urandom);
      tick();
      c++;
    end
    check("drain outstanding", 32'(outstanding()), 32'd0);
  endtask
  initial forever begin
    @(negedge clk_in);
    if (last_rdy && !rst_in) begin
      if (outstanding() < RS - 1) check("rs_full low", 32'(rs_full), 32'd0);
      if (pend.size() >= RS - 1) check("rs_full high", 32'(rs_full), 32'd1);
      if (rs_has_output) begin
        if (exp_val.exists(int'(rs_rob_id))) begin
          check($sformatf("result rob %0d", rs_rob_id), rs_output, exp_val[int'(rs_rob_id)]);
          exp_val.delete(int'(rs_rob_id));
          seen.push_back(int'(rs_rob_id));
        end else begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected broadcast: rob %0d value %h, required no broadcast", rs_rob_id, rs_output);
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the end, required completion");
    $fatal(1, "timeout");
  end
  initial begin
    int ids[7] = '{0, 1, 2, 3, 4, 6, 7};
    int fr[$];
    rst_in = 1'b1;
    rdy_in = 1'b1;
    rob_clear = 1'b0;
    is_ins = 1'b0;
    ins_op = '0;
    ins_is_br = 1'b0;
    ins_rob_id = '0;
    ins_rj_ready = 1'b0;
    ins_vj = '0;
    ins_qj = '0;
    ins_rk_ready = 1'b0;
    ins_vk = '0;
    ins_qk = '0;
    lsb_has_output = 1'b0;
    lsb_rob_id = '0;
    lsb_output = '0;
    tick();
    tick();
    rst_in = 1'b0;
    check("reset rs_rob_id", 32'(rs_rob_id), 32'd0);
    check("reset rs_output", rs_output, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle has_output", 32'(rs_has_output), 32'd0);
      check("idle rs_full", 32'(rs_full), 32'd0);
    end
    issue(4'h0, 1'b0, 3'd3, 1'b1, 32'd5, 3'd0, 1'b1, 32'd7, 3'd0);
    tick();
    check("add early", 32'(rs_has_output), 32'd0);
    tick();
    check("add valid", 32'(rs_has_output), 32'd1);
    check("add rob", 32'(rs_rob_id), 32'd3);
    check("add value", rs_output, 32'd12);
    tick();
    check("add one cycle", 32'(rs_has_output), 32'd0);
    issue(4'h8, 1'b0, 3'd1, 1'b0, 32'd0, 3'd2, 1'b1, 32'd1, 3'd0);
    tick();
    tick();
    lsb(3'd2, 32'd10);
    tick();
    check("sub wait early", 32'(rs_has_output), 32'd0);
    tick();
    check("sub wait valid", 32'(rs_has_output), 32'd1);
    check("sub wait value", rs_output, 32'd9);
    tick();
    issue(4'h8, 1'b0, 3'd1, 1'b0, 32'd0, 3'd2, 1'b1, 32'd1, 3'd0);
    lsb(3'd2, 32'd10);
    tick();
    check("sub bypass early", 32'(rs_has_output), 32'd0);
    tick();
    check("sub bypass valid", 32'(rs_has_output), 32'd1);
    check("sub bypass value", rs_output, 32'd9);
    tick();
    issue(4'h4, 1'b1, 3'd2, 1'b1, 32'hFFFFFFFF, 3'd0, 1'b1, 32'd1, 3'd0);
    tick();
    issue(4'h6, 1'b1, 3'd4, 1'b1, 32'hFFFFFFFF, 3'd0, 1'b1, 32'd1, 3'd0);
    tick();
    check("blt value", rs_output, 32'd1);
    issue(4'hd, 1'b0, 3'd6, 1'b1, 32'h80000000, 3'd0, 1'b1, 32'd4, 3'd0);
    tick();
    check("bltu value", rs_output, 32'd0);
    tick();
    check("sra value", rs_output, 32'hF8000000);
    tick();
    for (int i = 0; i < 7; i++) begin
      issue(4'h0, 1'b0, 3'(ids[i]), 1'b0, 32'd0, 3'd5, 1'b1, 32'(i), 3'd0);
      tick();
    end
    check("seven waiting full", 32'(rs_full), 32'd1);
    issue(4'h0, 1'b0, 3'd5, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
    tick();
    tick();
    check("eighth ignored", 32'(rs_has_output), 32'd0);
    seen.delete();
    lsb(3'd5, 32'd100);
    tick();
    drain(30);
    check("wake count", 32'(seen.size()), 32'd7);
    for (int i = 0; i < 7 && i < seen.size(); i++) check($sformatf("wake order %0d", i), 32'(seen[i]), 32'(ids[i]));
    check("full drops", 32'(rs_full), 32'd0);
    for (int i = 0; i < 3; i++) begin
      issue(4'h0, 1'b0, 3'(i), 1'b0, 32'd0, 3'd6, 1'b1, 32'd1, 3'd0);
      tick();
    end
    rob_clear = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("clear no output", 32'(rs_has_output), 32'd0);
    end
    check("clear full", 32'(rs_full), 32'd0);
    issue(4'h0, 1'b0, 3'd3, 1'b1, 32'd20, 3'd0, 1'b1, 32'd22, 3'd0);
    tick();
    tick();
    check("post clear valid", 32'(rs_has_output), 32'd1);
    check("post clear value", rs_output, 32'd42);
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic b;
      logic [3:0] o;
      logic [31:0] a;
      rdy_in = $urandom_range(7) != 0;
      if ($urandom_range(3) == 0) lsb(3'($urandom_range(7, 6)), $urandom_range(3) == 0 ? 32'($urandom_range(3)) : $urandom);
      if ($urandom_range(299) == 0) rob_clear = 1'b1;
      fr.delete();
      for (int r = 0; r < 6; r++) if (!used(r)) fr.push_back(r);
      if ($urandom_range(1) == 1 && outstanding() < RS - 1 && fr.size() != 0) begin
        b = $urandom_range(3) == 0;
        o = b ? {1'b0, br_ops[$urandom_range(5)]} : alu_ops[$urandom_range(9)];
        a = $urandom_range(3) == 0 ? 32'($urandom_range(3)) : $urandom;
        issue(o, b, 3'(fr[$urandom_range(fr.size() - 1)]),
              $urandom_range(2) != 0, a, 3'($urandom_range(7, 6)),
              $urandom_range(2) != 0, $urandom_range(3) == 0 ? a : $urandom, 3'($urandom_range(7, 6)));
      end
      tick();
    end
    rdy_in = 1'b1;
    drain(200);
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
